pixel_word_packer: RTL

//  Upstream feeder of the input-memory write controller. Accepts a valid/ready pixel stream and packs
//  PIX_PER_WORD pixels into one DATA_SIZE word. Generates sequential frame addresses and runs the write

---
 rtl/pixel_word_packer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pixel_word_packer.sv
// Pixel word packer: gathers PIX_PER_WORD pixels from a valid/ready stream into
// one wide word, then hands that word to the input-memory write controller at
// sequential frame addresses. Only one word is buffered at a time. A sticky
// error flag records any write that the controller never acknowledged.
// DATA_SIZE must equal PIX_WIDTH*PIX_PER_WORD for the packing to line up.
module pixel_word_packer #(
  parameter int ADD_SIZE     = 12,
  parameter int DATA_SIZE    = 108,
  parameter int PIX_WIDTH    = 12,
  parameter int PIX_PER_WORD = 9,
  parameter int BASE_ADDR    = 0,
  parameter int LAST_ADDR    = 4095,
  parameter int TIMEOUT      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid_i,
  input  logic [PIX_WIDTH-1:0] pix_data_i,
  output logic                 pix_ready_o,
  input  logic                 frame_start_i,
  output logic                 wc_in_valid_o,
  output logic                 wc_write_en_o,
  output logic [ADD_SIZE-1:0]  wc_address_o,
  output logic [DATA_SIZE-1:0] wc_data_o,
  input  logic                 wc_done_i,
  output logic                 frame_done_o,
  output logic                 err_o
);

  localparam int CW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]       LAST_PIX   = CW'(PIX_PER_WORD - 1);
  localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADD_SIZE-1:0] BASE       = ADD_SIZE'(BASE_ADDR);
  localparam logic [ADD_SIZE-1:0] LAST       = ADD_SIZE'(LAST_ADDR);

  typedef enum logic {
    COLLECT = 1'b0,
    REQ     = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [ADD_SIZE-1:0]  addr_q, addr_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 err_q, err_d;
  logic                 frame_done_q, frame_done_d;
  logic                 fs_pending_q, fs_pending_d;
  logic [CW-1:0]        idx;
  logic                 accept;

  // Output decode: strobes follow the state register directly, so an async
  // reset drops them in the same cycle; ready is also masked by reset itself.
  always_comb begin
    pix_ready_o   = (state_q == COLLECT) && !rst;
    wc_in_valid_o = (state_q == REQ);
    wc_write_en_o = (state_q == REQ);
    wc_address_o  = addr_q;
    wc_data_o     = data_q;
    frame_done_o  = frame_done_q;
    err_o         = err_q;
    accept        = pix_valid_i && pix_ready_o;
  end

  // Next-state logic: pack pixels while collecting, then hold the word in REQ
  // until the controller acknowledges it or the timeout gives up on it.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    addr_d       = addr_q;
    data_d       = data_q;
    timer_d      = timer_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    fs_pending_d = fs_pending_q;
    idx          = count_q;

    case (state_q)
      COLLECT: begin
        timer_d = '0;
        if (frame_start_i) begin
          idx          = '0;
          count_d      = '0;
          addr_d       = BASE;
          fs_pending_d = 1'b0;
        end
        if (accept) begin
          data_d[int'(idx)*PIX_WIDTH +: PIX_WIDTH] = pix_data_i;
          if (idx == LAST_PIX) begin
            count_d = '0;
            state_d = REQ;
          end else begin
            count_d = idx + CW'(1);
          end
        end
      end

      REQ: begin
        if (frame_start_i) begin
          fs_pending_d = 1'b1;
        end
        if (wc_done_i) begin
          state_d      = COLLECT;
          timer_d      = '0;
          frame_done_d = (addr_q == LAST);
          fs_pending_d = 1'b0;
          if (fs_pending_q || frame_start_i || (addr_q == LAST)) begin
            addr_d = BASE;
          end else begin
            addr_d = addr_q + ADD_SIZE'(1);
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d      = COLLECT;
          timer_d      = '0;
          err_d        = 1'b1;
          fs_pending_d = 1'b0;
          if (fs_pending_q || frame_start_i) begin
            addr_d = BASE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State register with asynchronous active-high reset back to an empty word
  // at the start of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      addr_q       <= BASE;
      data_q       <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      fs_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      fs_pending_q <= fs_pending_d;
    end
  end

endmodule
